product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator_pkg.sv | 14 +
 rtl/product_accumulator.sv | 107 ++++++++++
 tb/tb_product_accumulator.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
package product_accumulator_pkg;

    localparam int unsigned ACC_W_DEFAULT = 16;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_e;

endpackage

// File: rtl/product_accumulator.sv
// Sums N_TERMS multiplier products, then streams the 16-bit result out
// low byte first over a valid/ready byte interface.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = ACC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              acc_clr,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_c;
    logic               last_term_c;
    logic [15:0]        acc16_c;

    assign accept_c    = (state_q == ACCUM) && !acc_clr && prod_valid;
    assign last_term_c = (cnt_q == CNT_W'(N_TERMS - 1));
    assign acc16_c     = 16'(acc_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (accept_c && last_term_c) state_d = SEND_LO;
            SEND_LO: if (out_ready)               state_d = SEND_HI;
            SEND_HI: if (out_ready)               state_d = ACCUM;
            default:                              state_d = ACCUM;
        endcase
    end

    // Output decode; everything is a function of state and stored sum except
    // prod_ready, which drops combinationally while a clear is requested.
    always_comb begin
        prod_ready = 1'b0;
        out_valid  = 1'b0;
        out_byte   = '0;
        out_last   = 1'b0;
        unique case (state_q)
            ACCUM: begin
                prod_ready = !acc_clr;
            end
            SEND_LO: begin
                out_valid = 1'b1;
                out_byte  = acc16_c[7:0];
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_byte  = acc16_c[15:8];
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (cnt_q != '0) || (state_q != ACCUM);

    // Sum and term counter next values
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (state_q == ACCUM) begin
            if (acc_clr) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (accept_c) begin
                acc_d = acc_q + ACC_W'(prod_in);
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q == SEND_HI && out_ready) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: one N_TERMS=4 and one N_TERMS=1 instance.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] prod_in = '0;
    logic       prod_valid = 1'b0;
    logic       prod_ready;
    logic       acc_clr = 1'b0;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       busy;

    logic [7:0] b_prod_in = '0;
    logic       b_prod_valid = 1'b0;
    logic       b_prod_ready;
    logic [7:0] b_out_byte;
    logic       b_out_valid;
    logic       b_out_ready = 1'b1;
    logic       b_out_last;
    logic       b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(4), .ACC_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_clr    (acc_clr),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    product_accumulator #(.N_TERMS(1), .ACC_W(16)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (b_prod_in),
        .prod_valid (b_prod_valid),
        .prod_ready (b_prod_ready),
        .acc_clr    (1'b0),
        .out_byte   (b_out_byte),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_last   (b_out_last),
        .busy       (b_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one product for a single cycle; called at posedge+1.
    task automatic send(input logic [7:0] v);
        prod_valid = 1'b1;
        prod_in    = v;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod_in    = '0;
    endtask

    // Wait (bounded) for a result and consume both bytes with out_ready high.
    task automatic read_result(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        int waited = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_lo_valid"}, int'(out_valid), 1);
        check({tag, "_lo_byte"},  int'(out_byte),  int'(lo));
        check({tag, "_lo_last"},  int'(out_last),  0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_hi_valid"}, int'(out_valid), 1);
        check({tag, "_hi_byte"},  int'(out_byte),  int'(hi));
        check({tag, "_hi_last"},  int'(out_last),  1);
        @(posedge clk); #1;
    endtask

    logic [7:0] b_vals [3] = '{8'd0, 8'd255, 8'd1};

    initial begin
        // Reset values
        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_byte",  int'(out_byte),  0);
        check("rst_last",  int'(out_last),  0);
        check("rst_busy",  int'(busy),      0);
        check("rst_ready", int'(prod_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4 x 225 = 900 = 0x0384, back-to-back with out_ready high
        out_ready = 1'b1;
        repeat (4) send(8'd225);
        @(negedge clk);
        check("t1_ready_lo", int'(prod_ready), 0);
        check("t1_busy_lo",  int'(busy),       1);
        check("t1_lo_valid", int'(out_valid),  1);
        check("t1_lo_byte",  int'(out_byte),   'h84);
        check("t1_lo_last",  int'(out_last),   0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_hi_byte",  int'(out_byte),   'h03);
        check("t1_hi_last",  int'(out_last),   1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_idle_valid", int'(out_valid), 0);
        check("t1_idle_byte",  int'(out_byte),  0);
        check("t1_idle_busy",  int'(busy),      0);
        @(posedge clk); #1;

        // Backpressure in SEND_LO; acc_clr and prod_valid must be ignored there
        out_ready = 1'b0;
        repeat (4) send(8'd225);
        acc_clr    = 1'b1;
        prod_valid = 1'b1;
        prod_in    = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_valid", int'(out_valid),  1);
            check("t2_hold_byte",  int'(out_byte),   'h84);
            check("t2_hold_last",  int'(out_last),   0);
            check("t2_hold_ready", int'(prod_ready), 0);
            @(posedge clk); #1;
        end
        acc_clr    = 1'b0;
        prod_valid = 1'b0;
        prod_in    = '0;
        read_result("t2", 8'h84, 8'h03);
        @(negedge clk);
        check("t2_after_busy", int'(busy), 0);
        @(posedge clk); #1;

        // Clear abandons 6+9; the product offered with acc_clr is dropped
        send(8'd6);
        send(8'd9);
        acc_clr    = 1'b1;
        prod_valid = 1'b1;
        prod_in    = 8'd50;
        #1;
        check("t3_clr_ready", int'(prod_ready), 0);
        check("t3_clr_busy",  int'(busy),       1);
        @(posedge clk); #1;
        acc_clr    = 1'b0;
        prod_valid = 1'b0;
        prod_in    = '0;
        @(negedge clk);
        check("t3_post_busy",  int'(busy),       0);
        check("t3_post_ready", int'(prod_ready), 1);
        @(posedge clk); #1;
        repeat (4) send(8'd1);
        read_result("t3", 8'h04, 8'h00);

        // Reset while in SEND_HI drops the pending result
        out_ready = 1'b0;
        repeat (4) send(8'd5);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_in_hi_last", int'(out_last), 1);
        check("t4_in_hi_byte", int'(out_byte), 'h00);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", int'(out_valid),  0);
        check("t4_rst_byte",  int'(out_byte),   0);
        check("t4_rst_last",  int'(out_last),   0);
        check("t4_rst_busy",  int'(busy),       0);
        check("t4_rst_ready", int'(prod_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_no_resend", int'(out_valid), 0);
        @(posedge clk); #1;
        repeat (4) send(8'd2);
        read_result("t4", 8'h08, 8'h00);
        @(negedge clk);
        check("t4_done_valid", int'(out_valid), 0);
        @(posedge clk); #1;

        // N_TERMS=1: every product is a full result; ready low for two cycles
        for (int k = 0; k < 3; k++) begin
            b_prod_valid = 1'b1;
            b_prod_in    = b_vals[k];
            @(posedge clk); #1;
            b_prod_valid = 1'b0;
            b_prod_in    = '0;
            @(negedge clk);
            check("t5_lo_valid", int'(b_out_valid),  1);
            check("t5_lo_byte",  int'(b_out_byte),   int'(b_vals[k]));
            check("t5_lo_last",  int'(b_out_last),   0);
            check("t5_lo_ready", int'(b_prod_ready), 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("t5_hi_byte",  int'(b_out_byte),   0);
            check("t5_hi_last",  int'(b_out_last),   1);
            check("t5_hi_ready", int'(b_prod_ready), 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("t5_idle_ready", int'(b_prod_ready), 1);
            check("t5_idle_valid", int'(b_out_valid),  0);
            check("t5_idle_busy",  int'(b_busy),       0);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
